// File: rtl/sim_ctrl_pkg.sv
// Shared types and Q20.12 constants for the simulation-step control blocks.
package sim_ctrl_pkg;

  localparam int unsigned POS_W     = 32;
  localparam int unsigned FRAC_BITS = 12;
  localparam logic [POS_W-1:0] FIX_ONE = 32'h0000_1000;

  typedef enum logic [2:0] {
    IDLE,
    VERLET,
    WAIT_V,
    SOLVE,
    WRITE,
    WAIT_W,
    DONE
  } sched_state_t;

endpackage

// File: rtl/verlet_step_scheduler.sv
// One simulation step: Verlet broadcast, then ITERATIONS relaxation sweeps over
// node pairs (i-1, i) through the shared solver, writing results into node i.
module verlet_step_scheduler
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_NODES  = 8,
  parameter int unsigned ITERATIONS = 4,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_start,
  output logic                 verlet_state,
  input  logic [NUM_NODES-1:0] node_finish,
  output logic                 solve_req,
  output logic [IDX_W-1:0]     solve_idx,
  input  logic                 solve_ack,
  input  logic [POS_W-1:0]     solve_x,
  input  logic [POS_W-1:0]     solve_y,
  output logic [NUM_NODES-1:0] fix_constraint_state,
  output logic [POS_W-1:0]     x_fix_constraint,
  output logic [POS_W-1:0]     y_fix_constraint,
  output logic                 busy,
  output logic                 step_done
);

  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_NODES - 1);
  localparam logic [3:0]           LAST_ITER = 4'((ITERATIONS == 0) ? 0 : ITERATIONS - 1);
  localparam bit                   NO_RELAX  = (NUM_NODES == 1) || (ITERATIONS == 0);
  localparam logic [NUM_NODES-1:0] NODE0     = NUM_NODES'(1);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           iter_q, iter_d;
  logic [POS_W-1:0]     x_cap_d, y_cap_d;
  logic [NUM_NODES-1:0] idx_mask_q;
  logic [NUM_NODES-1:0] fix_d;

  // Node-select mask for the current pair's upper node (node 0 is never selected).
  assign idx_mask_q = (NODE0 << idx_q) & ~NODE0;

  // Next-state, counter and capture logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    x_cap_d = x_fix_constraint;
    y_cap_d = y_fix_constraint;
    case (state_q)
      IDLE: begin
        if (step_start) state_d = VERLET;
      end
      VERLET: state_d = WAIT_V;
      WAIT_V: begin
        if (&node_finish) begin
          if (NO_RELAX) begin
            state_d = DONE;
          end else begin
            idx_d   = IDX_W'(1);
            iter_d  = 4'd0;
            state_d = SOLVE;
          end
        end
      end
      SOLVE: begin
        if (solve_ack) begin
          x_cap_d = solve_x;
          y_cap_d = solve_y;
          state_d = WRITE;
        end
      end
      WRITE: state_d = WAIT_W;
      WAIT_W: begin
        if (|(node_finish & idx_mask_q)) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SOLVE;
          end else if (iter_q < LAST_ITER) begin
            iter_d  = iter_q + 4'd1;
            idx_d   = IDX_W'(1);
            state_d = SOLVE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe for the upcoming cycle, decoded from the next state.
  always_comb begin
    fix_d = '0;
    if (state_d == WRITE) fix_d = (NODE0 << idx_d) & ~NODE0;
  end

  // State, counters, captures and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      idx_q                <= '0;
      iter_q               <= '0;
      x_fix_constraint     <= '0;
      y_fix_constraint     <= '0;
      verlet_state         <= 1'b0;
      solve_req            <= 1'b0;
      solve_idx            <= '0;
      fix_constraint_state <= '0;
      busy                 <= 1'b0;
      step_done            <= 1'b0;
    end else begin
      state_q              <= state_d;
      idx_q                <= idx_d;
      iter_q               <= iter_d;
      x_fix_constraint     <= x_cap_d;
      y_fix_constraint     <= y_cap_d;
      verlet_state         <= (state_d == VERLET);
      solve_req            <= (state_d == SOLVE);
      solve_idx            <= idx_d;
      fix_constraint_state <= fix_d;
      busy                 <= (state_d != IDLE);
      step_done            <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_verlet_step_scheduler.sv
// Bench for verlet_step_scheduler: directed cycle table plus randomized steps
// checked against a step-level timing/ordering model.
module tb_verlet_step_scheduler;
  import sim_ctrl_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IT = 2;
  localparam int unsigned IW = 2;
  localparam int unsigned M  = (N - 1) * IT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step_start = 1'b0, deg_start = 1'b0, ack_force = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  node_finish;
  logic          verlet_state, solve_req, solve_ack, busy, step_done;
  logic [IW-1:0] solve_idx;
  logic [31:0]   solve_x, solve_y, x_fix, y_fix;
  logic [N-1:0]  fix;

  verlet_step_scheduler #(.NUM_NODES(N), .ITERATIONS(IT), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .step_start(step_start), .verlet_state(verlet_state),
    .node_finish(node_finish), .solve_req(solve_req), .solve_idx(solve_idx),
    .solve_ack(solve_ack), .solve_x(solve_x), .solve_y(solve_y),
    .fix_constraint_state(fix), .x_fix_constraint(x_fix), .y_fix_constraint(y_fix),
    .busy(busy), .step_done(step_done));

  // Degenerate configurations: no sweeps, and a single node.
  logic       a_verlet, a_req, a_busy, a_done;
  logic [1:0] a_idx;
  logic [3:0] a_fix;
  logic [31:0] a_x, a_y;
  verlet_step_scheduler #(.NUM_NODES(4), .ITERATIONS(0), .IDX_W(2)) dut_i0 (
    .clk(clk), .reset(reset), .step_start(deg_start), .verlet_state(a_verlet),
    .node_finish(4'hF), .solve_req(a_req), .solve_idx(a_idx), .solve_ack(1'b1),
    .solve_x(FIX_ONE), .solve_y(FIX_ONE), .fix_constraint_state(a_fix),
    .x_fix_constraint(a_x), .y_fix_constraint(a_y), .busy(a_busy), .step_done(a_done));

  logic       b_verlet, b_req, b_busy, b_done;
  logic [0:0] b_idx;
  logic [0:0] b_fix;
  logic [31:0] b_x, b_y;
  verlet_step_scheduler #(.NUM_NODES(1), .ITERATIONS(4), .IDX_W(1)) dut_n1 (
    .clk(clk), .reset(reset), .step_start(deg_start), .verlet_state(b_verlet),
    .node_finish(1'b1), .solve_req(b_req), .solve_idx(b_idx), .solve_ack(1'b1),
    .solve_x(FIX_ONE), .solve_y(FIX_ONE), .fix_constraint_state(b_fix),
    .x_fix_constraint(b_x), .y_fix_constraint(b_y), .busy(b_busy), .step_done(b_done));

  // Environment: solver with per-request ack delay, nodes with per-strobe finish delay.
  int unsigned ack_d [64];
  int unsigned fin_d [64];
  int unsigned vdelay [N];
  logic [31:0] xd [64];
  logic [31:0] yd [64];
  logic [5:0]  ac, fc;
  int unsigned req_cnt;
  int unsigned fcnt [N];

  assign solve_ack = ack_force | (solve_req && (req_cnt == ack_d[ac]));
  assign solve_x   = xd[ac];
  assign solve_y   = yd[ac];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ac <= '0; fc <= '0; req_cnt <= 0; node_finish <= '0;
      for (int n = 0; n < N; n++) fcnt[n] <= 0;
    end else begin
      if (solve_req && solve_ack) begin ac <= ac + 6'd1; req_cnt <= 0; end
      else if (solve_req) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
      for (int n = 0; n < N; n++) begin
        if (verlet_state || fix[n]) begin
          node_finish[n] <= ((verlet_state ? vdelay[n] : fin_d[fc]) == 0);
          fcnt[n]        <= verlet_state ? vdelay[n] : fin_d[fc];
        end else if (fcnt[n] != 0) begin
          fcnt[n] <= fcnt[n] - 1;
          if (fcnt[n] == 1) node_finish[n] <= 1'b1;
        end
      end
      if (|fix) fc <= fc + 6'd1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned exp_idx(input int unsigned c);
    return (c % (N - 1)) + 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step_start = 1'b0; deg_start = 1'b0; ack_force = 1'b0;
    @(negedge clk);
    check("rst_outputs", {verlet_state, solve_req, solve_idx, fix, busy, step_done}, '0);
    check("rst_pos", {x_fix, y_fix}, '0);
    reset = 1'b0;
  endtask

  // One step under the environment settings; expectations from the step rules.
  task automatic run_model_step(input bit spurious);
    int unsigned vmax, done_t, wc, rc, pend_idx;
    bit pend;
    vmax = 0; wc = 0; rc = 0; pend = 0; pend_idx = 0;
    for (int n = 0; n < N; n++) if (vdelay[n] > vmax) vmax = vdelay[n];
    done_t = 3 + vmax;
    for (int c = 0; c < M; c++) done_t += 3 + ack_d[c] + fin_d[c];
    @(negedge clk);
    check("idle_c0", {verlet_state, solve_req, fix, busy, step_done}, '0);
    step_start = 1'b1;
    for (int t = 1; t <= int'(done_t) + 2; t++) begin
      @(negedge clk);
      step_start = spurious && (t <= int'(done_t)) && ($urandom_range(0, 3) == 0);
      check("busy", busy, t <= int'(done_t));
      check("step_done", step_done, t == int'(done_t));
      check("verlet", verlet_state, t == 1);
      check("exclusive", (verlet_state && |fix) || !$onehot0(fix) || fix[0], 0);
      check("early_req", solve_req && (t < int'(3 + vmax)), 0);
      if (pend) check("req_hold", {solve_req, 30'(solve_idx)}, {1'b1, 30'(pend_idx)});
      if (|fix) begin
        check("write_cnt", wc < M, 1);
        check("write_strobe", fix, N'(1) << exp_idx(wc));
        check("write_x", x_fix, xd[wc & 63]);
        check("write_y", y_fix, yd[wc & 63]);
        wc++;
      end
      pend = 0;
      if (solve_req) begin
        check("solve_idx", solve_idx, exp_idx(rc));
        pend_idx = exp_idx(rc);
        if (solve_ack) rc++;
        else pend = 1;
      end
    end
    step_start = 1'b0;
    check("writes_total", wc, M);
    check("acks_total", rc, M);
  endtask

  typedef struct {
    logic          start, dstart, ackf;
    logic          verlet, req, busy, done;
    logic [IW-1:0] idx;
    logic [N-1:0]  fix;
    logic [31:0]   x, y;
    logic          d_verlet, d_busy, d_done;
  } vec_t;

  vec_t tbl [26];

  initial begin
    for (int n = 0; n < N; n++) vdelay[n] = 0;
    for (int c = 0; c < 64; c++) begin
      ack_d[c] = 0; fin_d[c] = 0; xd[c] = $urandom; yd[c] = $urandom;
    end

    // Directed cycle table, zero-wait environment; start at cycle 0.
    for (int j = 0; j < 26; j++) begin
      int c, ph, cx;
      c  = (j - 3) / 3;
      ph = (j - 3) % 3;
      cx = (j < 4) ? 0 : (((j - 4) / 3 > 5) ? 5 : (j - 4) / 3);
      tbl[j].start    = (j == 0) || (j == 10) || (j == 21);
      tbl[j].dstart   = (j == 0);
      tbl[j].ackf     = (j == 0) || (j == 23) || (j == 24);
      tbl[j].verlet   = (j == 1);
      tbl[j].busy     = (j >= 1) && (j <= 21);
      tbl[j].done     = (j == 21);
      tbl[j].req      = (j >= 3) && (j <= 20) && (ph == 0);
      tbl[j].idx      = IW'(exp_idx(c < 0 ? 0 : c));
      tbl[j].fix      = ((j >= 3) && (j <= 20) && (ph == 1)) ? N'(1) << exp_idx(c) : '0;
      tbl[j].x        = (j < 4) ? 32'h0 : xd[cx];
      tbl[j].y        = (j < 4) ? 32'h0 : yd[cx];
      tbl[j].d_verlet = (j == 1);
      tbl[j].d_busy   = (j >= 1) && (j <= 3);
      tbl[j].d_done   = (j == 3);
    end

    do_reset();
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      check("t_verlet", verlet_state, tbl[j].verlet);
      check("t_busy", busy, tbl[j].busy);
      check("t_done", step_done, tbl[j].done);
      check("t_req", solve_req, tbl[j].req);
      if (tbl[j].req) check("t_idx", solve_idx, tbl[j].idx);
      check("t_fix", fix, tbl[j].fix);
      check("t_x", x_fix, tbl[j].x);
      check("t_y", y_fix, tbl[j].y);
      check("i0_ctl", {a_verlet, a_busy, a_done, a_req, a_fix},
            {tbl[j].d_verlet, tbl[j].d_busy, tbl[j].d_done, 1'b0, 4'b0});
      check("n1_ctl", {b_verlet, b_busy, b_done, b_req, b_fix},
            {tbl[j].d_verlet, tbl[j].d_busy, tbl[j].d_done, 1'b0, 1'b0});
      step_start = tbl[j].start;
      deg_start  = tbl[j].dstart;
      ack_force  = tbl[j].ackf;
    end
    step_start = 1'b0; deg_start = 1'b0; ack_force = 1'b0;

    // Solver answers each request 5 cycles late with fixed positions.
    do_reset();
    for (int c = 0; c < 64; c++) begin
      ack_d[c] = 5; fin_d[c] = 0; xd[c] = 32'h000C_8000; yd[c] = 32'h0000_A000;
    end
    run_model_step(1'b0);

    // Node 2 finishes Verlet 4 cycles late.
    do_reset();
    for (int c = 0; c < 64; c++) begin ack_d[c] = 0; xd[c] = FIX_ONE * (c + 1); yd[c] = ~xd[c]; end
    vdelay[2] = 4;
    run_model_step(1'b1);
    vdelay[2] = 0;

    // Randomized delays and positions, with spurious starts while busy.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int n = 0; n < N; n++) vdelay[n] = $urandom_range(0, 3);
      for (int c = 0; c < 64; c++) begin
        ack_d[c] = $urandom_range(0, 3); fin_d[c] = $urandom_range(0, 3);
        xd[c] = $urandom; yd[c] = $urandom;
      end
      run_model_step(1'b1);
    end

    // Reset in the middle of SOLVE, then a clean step.
    do_reset();
    for (int n = 0; n < N; n++) vdelay[n] = 0;
    for (int c = 0; c < 64; c++) begin ack_d[c] = 0; fin_d[c] = 0; end
    ack_d[0] = 20;
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    for (int t = 0; t < 10 && !solve_req; t++) @(negedge clk);
    check("mid_req_seen", solve_req, 1);
    #2 reset = 1'b1;
    #1 check("mid_rst_outputs",
             {verlet_state, solve_req, solve_idx, fix, busy, step_done, x_fix, y_fix}, '0);
    @(negedge clk);
    reset = 1'b0;
    ack_d[0] = 0;
    run_model_step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
